// File: rtl/sched_pkg.sv
// Shared constants, the default-width task record and the queue-count width helper
// for the priority task scheduler.
package sched_pkg;

    localparam int DEF_NUM_CORES   = 4;
    localparam int DEF_PRIO_W      = 3;
    localparam int DEF_DUR_W       = 8;
    localparam int DEF_ID_W        = 4;
    localparam int DEF_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [DEF_PRIO_W-1:0] prio;
        logic [DEF_DUR_W-1:0]  dur;
        logic [DEF_ID_W-1:0]   id;
    } task_t;

    // Width able to hold every occupancy value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sched_core_timer.sv
// One execution core: loads a task, counts its duration down to zero and pulses
// done for one cycle on the edge where it finishes.
module sched_core_timer
    import sched_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_dur,
    input  logic [ID_W-1:0]  load_id,
    output logic             busy,
    output logic [DUR_W-1:0] remaining,
    output logic [ID_W-1:0]  task_id,
    output logic             done
);

    logic             busy_reg;
    logic [DUR_W-1:0] time_reg;
    logic [ID_W-1:0]  id_reg;
    logic             done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= 1'b0;
            time_reg <= '0;
            id_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                busy_reg <= 1'b1;
                // A zero duration still occupies the core for one cycle.
                time_reg <= (load_dur == '0) ? DUR_W'(1) : load_dur;
                id_reg   <= load_id;
            end else if (busy_reg) begin
                if (time_reg == DUR_W'(1)) begin
                    time_reg <= '0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    time_reg <= time_reg - DUR_W'(1);
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign remaining = time_reg;
    assign task_id   = id_reg;
    assign done      = done_reg;

endmodule

// File: rtl/prio_task_scheduler.sv
// Bounded age-ordered task queue with a highest-priority/oldest selector that
// dispatches at most one task per cycle to the lowest-numbered idle core.
module prio_task_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int PRIO_W      = DEF_PRIO_W,
    parameter int DUR_W       = DEF_DUR_W,
    parameter int ID_W        = DEF_ID_W,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              task_valid,
    output logic                              task_ready,
    input  logic [PRIO_W-1:0]                 task_priority,
    input  logic [DUR_W-1:0]                  task_duration,
    input  logic [ID_W-1:0]                   task_id,
    output logic [NUM_CORES-1:0]              core_busy,
    output logic [NUM_CORES*DUR_W-1:0]        core_task_time,
    output logic [NUM_CORES*ID_W-1:0]         core_task_id,
    output logic [NUM_CORES-1:0]              core_done,
    output logic [count_width(QUEUE_DEPTH)-1:0] queue_count
);

    localparam int CNT_W = count_width(QUEUE_DEPTH);

    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [DUR_W-1:0]  dur;
        logic [ID_W-1:0]   id;
    } slot_t;

    slot_t                slots_reg  [QUEUE_DEPTH];
    slot_t                slots_next [QUEUE_DEPTH];
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic [CNT_W-1:0]     tail_idx;

    logic                 has_cand;
    logic [CNT_W-1:0]     sel_idx;
    logic [PRIO_W-1:0]    sel_prio;
    slot_t                sel_slot;
    logic                 has_idle;
    logic [NUM_CORES-1:0] load_vec;
    logic                 accept;
    logic                 dispatch;

    // Ready looks only at the registered count, so a same-edge dispatch never frees a slot early.
    assign task_ready  = (count_reg < CNT_W'(QUEUE_DEPTH));
    assign accept      = task_valid && task_ready;
    assign queue_count = count_reg;

    // Strict '>' keeps the lowest (oldest) slot among equal priorities.
    always_comb begin
        has_cand = 1'b0;
        sel_idx  = '0;
        sel_prio = '0;
        sel_slot = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((CNT_W'(i) < count_reg) && (!has_cand || (slots_reg[i].prio > sel_prio))) begin
                has_cand = 1'b1;
                sel_idx  = CNT_W'(i);
                sel_prio = slots_reg[i].prio;
                sel_slot = slots_reg[i];
            end
        end
    end

    // A core finishing on this edge still shows busy, so it is only picked on the next one.
    always_comb begin
        has_idle = 1'b0;
        load_vec = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (!core_busy[c] && !has_idle) begin
                has_idle    = 1'b1;
                load_vec[c] = has_cand;
            end
        end
    end

    assign dispatch = has_cand && has_idle;
    assign tail_idx = count_reg - CNT_W'(dispatch);

    always_comb begin
        slots_next = slots_reg;
        if (dispatch) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                if (CNT_W'(i) >= sel_idx) begin
                    slots_next[i] = slots_reg[i+1];
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (CNT_W'(i) == tail_idx) begin
                    slots_next[i].prio = task_priority;
                    slots_next[i].dur  = task_duration;
                    slots_next[i].id   = task_id;
                end
            end
        end
        count_next = count_reg + CNT_W'(accept) - CNT_W'(dispatch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slots_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            slots_reg <= slots_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            sched_core_timer #(
                .DUR_W (DUR_W),
                .ID_W  (ID_W)
            ) u_timer (
                .clk       (clk),
                .reset     (reset),
                .load      (load_vec[gi]),
                .load_dur  (sel_slot.dur),
                .load_id   (sel_slot.id),
                .busy      (core_busy[gi]),
                .remaining (core_task_time[gi*DUR_W +: DUR_W]),
                .task_id   (core_task_id[gi*ID_W +: ID_W]),
                .done      (core_done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_prio_task_scheduler.sv
// Randomised and directed bench for prio_task_scheduler; a queue-based reference
// model feeds expected per-cycle state, dispatch and completion events to a monitor.
module tb_prio_task_scheduler;
    import sched_pkg::*;

    localparam int NC    = DEF_NUM_CORES;
    localparam int DW    = DEF_DUR_W;
    localparam int IW    = DEF_ID_W;
    localparam int PW    = DEF_PRIO_W;
    localparam int QD    = DEF_QUEUE_DEPTH;
    localparam int CNT_W = count_width(QD);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 task_valid;
    logic                 task_ready;
    logic [PW-1:0]        task_priority;
    logic [DW-1:0]        task_duration;
    logic [IW-1:0]        task_id;
    logic [NC-1:0]        core_busy;
    logic [NC*DW-1:0]     core_task_time;
    logic [NC*IW-1:0]     core_task_id;
    logic [NC-1:0]        core_done;
    logic [CNT_W-1:0]     queue_count;

    always #5 clk = ~clk;

    prio_task_scheduler #(
        .NUM_CORES   (NC),
        .PRIO_W      (PW),
        .DUR_W       (DW),
        .ID_W        (IW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .task_valid     (task_valid),
        .task_ready     (task_ready),
        .task_priority  (task_priority),
        .task_duration  (task_duration),
        .task_id        (task_id),
        .core_busy      (core_busy),
        .core_task_time (core_task_time),
        .core_task_id   (core_task_id),
        .core_done      (core_done),
        .queue_count    (queue_count)
    );

    typedef struct { int core; int id; int tm; } ev_t;
    typedef struct {
        int            count;
        bit            ready;
        logic [NC-1:0]    busy;
        logic [NC*DW-1:0] times;
        logic [NC*IW-1:0] ids;
        logic [NC-1:0]    done;
    } state_t;

    ev_t    disp_q [$];
    ev_t    done_q [$];
    state_t state_q[$];

    // Reference model: arrival-ordered pending list plus per-core remaining time.
    task_t pend_q [$];
    int    m_rem  [NC];
    int    m_id   [NC];
    bit    m_busy [NC];

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic task_t mk(input int p, input int d, input int i);
        task_t t;
        t.prio = PW'(p);
        t.dur  = DW'(d);
        t.id   = IW'(i);
        return t;
    endfunction

    // Drive one cycle of stimulus, advance the model across the coming edge, queue expectations.
    task automatic step(input bit rst, input bit v, input task_t t, output bit acc);
        state_t s;
        ev_t    e;
        int     tgt;
        int     k;
        reset         = rst;
        task_valid    = v;
        task_priority = t.prio;
        task_duration = t.dur;
        task_id       = t.id;
        acc           = 1'b0;
        s.done        = '0;
        if (rst) begin
            pend_q.delete();
            for (int c = 0; c < NC; c++) begin
                m_rem[c] = 0; m_id[c] = 0; m_busy[c] = 1'b0;
            end
        end else begin
            acc = v && (pend_q.size() < QD);
            tgt = -1;
            for (int c = 0; c < NC; c++) if (!m_busy[c] && tgt < 0) tgt = c;
            k = -1;
            if (tgt >= 0)
                for (int j = 0; j < pend_q.size(); j++)
                    if (k < 0 || pend_q[j].prio > pend_q[k].prio) k = j;
            for (int c = 0; c < NC; c++) begin
                if (m_busy[c]) begin
                    if (m_rem[c] == 1) begin
                        m_rem[c] = 0; m_busy[c] = 1'b0; s.done[c] = 1'b1;
                        e.core = c; e.id = m_id[c]; e.tm = 0;
                        done_q.push_back(e);
                    end else begin
                        m_rem[c]--;
                    end
                end
            end
            if (k >= 0) begin
                m_busy[tgt] = 1'b1;
                m_rem[tgt]  = (pend_q[k].dur == 0) ? 1 : int'(pend_q[k].dur);
                m_id[tgt]   = int'(pend_q[k].id);
                e.core = tgt; e.id = m_id[tgt]; e.tm = m_rem[tgt];
                disp_q.push_back(e);
                pend_q.delete(k);
            end
            if (acc) pend_q.push_back(t);
        end
        s.count = pend_q.size();
        s.ready = (s.count < QD);
        for (int c = 0; c < NC; c++) begin
            s.busy[c]               = m_busy[c];
            s.times[c*DW +: DW]     = DW'(m_rem[c]);
            s.ids[c*IW +: IW]       = IW'(m_id[c]);
        end
        state_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic offer(input task_t t);
        bit a;
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b1, t, a);
            n++;
        end while (!a && n < 300);
        if (!a) begin
            vectors++;
            miscompares++;
            $display("FAIL offer_timeout: id %0d never accepted", t.id);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, mk(0, 0, 0), a);
    endtask

    // Monitor: checks outputs after each rising edge, away from the edge itself.
    initial begin
        state_t        s;
        ev_t           e;
        logic [NC-1:0] prev_busy;
        prev_busy = '0;
        forever begin
            @(posedge clk);
            #2;
            if (state_q.size() > 0) begin
                s = state_q.pop_front();
                chk("queue_count", 64'(queue_count), 64'(s.count));
                chk("task_ready", 64'(task_ready), 64'(s.ready));
                chk("core_busy", 64'(core_busy), 64'(s.busy));
                chk("core_task_time", 64'(core_task_time), 64'(s.times));
                chk("core_task_id", 64'(core_task_id), 64'(s.ids));
                chk("core_done", 64'(core_done), 64'(s.done));
            end
            for (int c = 0; c < NC; c++) begin
                if (core_done[c] === 1'b1) begin
                    if (done_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL done_unexpected: core %0d pulsed, none expected", c);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_core", 64'(c), 64'(e.core));
                        chk("done_id", 64'(core_task_id[c*IW +: IW]), 64'(e.id));
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (core_busy[c] === 1'b1 && prev_busy[c] !== 1'b1) begin
                    if (disp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL dispatch_unexpected: core %0d started, none expected", c);
                    end else begin
                        e = disp_q.pop_front();
                        chk("dispatch_core", 64'(c), 64'(e.core));
                        chk("dispatch_id", 64'(core_task_id[c*IW +: IW]), 64'(e.id));
                        chk("dispatch_time", 64'(core_task_time[c*DW +: DW]), 64'(e.tm));
                    end
                end
            end
            prev_busy = core_busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit    a;
        bit    have;
        task_t t;
        reset         = 1'b1;
        task_valid    = 1'b0;
        task_priority = '0;
        task_duration = '0;
        task_id       = '0;
        @(negedge clk);
        step(1'b1, 1'b0, mk(0, 0, 0), a);

        // single task
        offer(mk(3, 10, 1));
        idle(14);

        // priority order behind busy cores
        for (int i = 0; i < NC; i++) offer(mk(0, 20, 8 + i));
        offer(mk(1, 5, 1));
        offer(mk(3, 5, 3));
        offer(mk(2, 5, 2));
        idle(40);

        // age tie-break at equal priority
        for (int i = 0; i < NC; i++) offer(mk(1, 15, 12 + i));
        offer(mk(2, 4, 2));
        offer(mk(2, 4, 5));
        offer(mk(2, 4, 7));
        idle(30);

        // full queue with a held ninth/tenth task
        for (int i = 0; i < NC; i++) offer(mk(0, 30, i));
        for (int i = 0; i < QD + 2; i++) offer(mk(i % 8, 3, i));
        idle(60);

        // zero duration tasks queued behind staggered cores
        for (int i = 0; i < NC; i++) offer(mk(0, 6, i));
        for (int i = 0; i < NC; i++) offer(mk(i, 0, 4 + i));
        idle(12);

        // reset with busy cores and three queued tasks
        for (int i = 0; i < NC; i++) offer(mk(1, 20, i));
        for (int i = 0; i < 3; i++) offer(mk(2, 9, 9 + i));
        idle(3);
        step(1'b1, 1'b0, mk(0, 0, 0), a);
        idle(4);

        // random traffic, valid held until accepted
        have = 1'b0;
        t    = mk(0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if (!have && $urandom_range(0, 99) < ((i < 750) ? 75 : 30)) begin
                have = 1'b1;
                t = mk($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 15));
            end
            step(1'b0, have, t, a);
            if (a) have = 1'b0;
        end
        idle(80);

        @(posedge clk);
        #5;
        chk("drain_pending_dispatch", 64'(disp_q.size()), 64'(0));
        chk("drain_pending_done", 64'(done_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
